// File: rtl/dtc_code_gen.sv
// dtc_code_gen: fractional-N phase accumulator feeding a DTC.
// Stage 1 accumulates the fractional FCW and forms the divide ratio and the
// recentred residue; stage 2 scales the residue by the DTC gain, applies
// first-order error feedback and saturates to the DTC code range.
module dtc_code_gen #(
    parameter int FRAC_WIDTH = 24,
    parameter int INT_WIDTH  = 8,
    parameter int DIN_WIDTH  = 10,
    parameter int GAIN_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        fcw_load,
    input  logic [INT_WIDTH-1:0]        fcw_int,
    input  logic [FRAC_WIDTH-1:0]       fcw_frac,
    input  logic [GAIN_WIDTH-1:0]       kdtc_gain,
    output logic [INT_WIDTH:0]          div_ratio,
    output logic signed [DIN_WIDTH-1:0] d_out,
    output logic                        d_valid,
    output logic                        ovf_flag
);

    localparam int SH = GAIN_WIDTH + 3;       // error-feedback fraction bits
    localparam int TW = DIN_WIDTH + 4;        // truncated residue width
    localparam int PW = TW + GAIN_WIDTH + 1;  // product width
    localparam int SW = PW + 1;               // product + error width
    localparam int QW = SW - SH;              // quotient width before clamp

    localparam logic [FRAC_WIDTH-1:0]       MID  = {1'b1, {(FRAC_WIDTH-1){1'b0}}};
    localparam logic signed [QW-1:0]        QMAX = {{(QW-DIN_WIDTH+1){1'b0}}, {(DIN_WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0]        QMIN = ~QMAX;
    localparam logic signed [DIN_WIDTH-1:0] DMAX = {1'b0, {(DIN_WIDTH-1){1'b1}}};
    localparam logic signed [DIN_WIDTH-1:0] DMIN = ~DMAX;

    // Active FCW registers
    logic [INT_WIDTH-1:0]  fcw_int_q;
    logic [FRAC_WIDTH-1:0] fcw_frac_q;

    // Stage 1 state; only the top TW bits of the recentred residue are ever
    // consumed by stage 2, so only those are stored.
    logic [FRAC_WIDTH-1:0] acc;
    logic [INT_WIDTH:0]    r1_div;
    logic signed [TW-1:0]  r1_t;
    logic                  v1;
    logic                  v2;

    // Stage 2 state
    logic [SH-1:0] err;

    // Combinational datapath
    logic [FRAC_WIDTH:0]   acc_sum;
    logic [FRAC_WIDTH-1:0] cen;
    logic [INT_WIDTH:0]    div_next;
    logic signed [PW-1:0]  p;
    logic signed [SW-1:0]  s;
    logic signed [QW-1:0]  q;
    logic                  sat_hi;
    logic                  sat_lo;

    // Stage 1 combinational: accumulate, carry into divide ratio, recentre residue
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, fcw_frac_q};
        cen      = acc_sum[FRAC_WIDTH-1:0] - MID;
        div_next = {1'b0, fcw_int_q} + {{INT_WIDTH{1'b0}}, acc_sum[FRAC_WIDTH]};
    end

    // Stage 2 combinational: gain scaling, error feedback, floor quantisation, range test
    always_comb begin
        p      = PW'(r1_t) * PW'($signed({1'b0, kdtc_gain}));
        s      = SW'(p) + SW'($signed({1'b0, err}));
        q      = s[SW-1:SH];
        sat_hi = (q > QMAX);
        sat_lo = (q < QMIN);
    end

    // Active FCW capture; a coincident step still sees the previous FCW
    // NOTE: non-blocking assignments let every register sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw_int_q  <= '0;
            fcw_frac_q <= '0;
        end else if (fcw_load) begin
            fcw_int_q  <= fcw_int;
            fcw_frac_q <= fcw_frac;
        end
    end

    // Stage 1 registers, advanced on each enabled step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            r1_div <= '0;
            r1_t   <= '0;
        end else if (en) begin
            acc    <= acc_sum[FRAC_WIDTH-1:0];
            r1_div <= div_next;
            r1_t   <= cen[FRAC_WIDTH-1 -: TW];
        end
    end

    // Stage 2 registers: output code with saturation and error-feedback residue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ratio <= '0;
            d_out     <= '0;
            err       <= '0;
        end else if (v1) begin
            div_ratio <= r1_div;
            if (sat_hi) begin
                d_out <= DMAX;
                err   <= '0;
            end else if (sat_lo) begin
                d_out <= DMIN;
                err   <= '0;
            end else begin
                d_out <= q[DIN_WIDTH-1:0];
                err   <= s[SH-1:0];
            end
        end
    end

    // Valid pipeline tracking each step through both stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= en;
            v2 <= v1;
        end
    end

    assign d_valid = v2;

    // Sticky saturation flag; a saturation on the same edge as a reload keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
        end else if (v1 && (sat_hi || sat_lo)) begin
            ovf_flag <= 1'b1;
        end else if (fcw_load) begin
            ovf_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dtc_code_gen.sv
// Self-checking bench for dtc_code_gen: table-driven vectors plus hand-written
// sequences, with a scoreboard queue of expected results keyed by due cycle.
module tb_dtc_code_gen;

    typedef struct {
        bit                 en;
        bit                 load;
        logic [7:0]         fi;
        logic [23:0]        ff;
        logic [11:0]        gain;
        logic [8:0]         xdiv;
        logic signed [9:0]  xd;
    } vec_t;

    typedef struct {
        int                 due;
        logic [8:0]         div;
        logic signed [9:0]  d;
        bit                 dc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              fcw_load = 1'b0;
    logic [7:0]        fcw_int = '0;
    logic [23:0]       fcw_frac = '0;
    logic [11:0]       kdtc_gain = '0;
    logic [8:0]        div_ratio;
    logic signed [9:0] d_out;
    logic              d_valid;
    logic              ovf_flag;

    dtc_code_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fcw_load  (fcw_load),
        .fcw_int   (fcw_int),
        .fcw_frac  (fcw_frac),
        .kdtc_gain (kdtc_gain),
        .div_ratio (div_ratio),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .ovf_flag  (ovf_flag)
    );

    always #5 clk = ~clk;

    int                nvec = 0;
    int                nbad = 0;
    int                cyc = 0;
    exp_t              sb[$];
    vec_t              tbl[$];
    logic [8:0]        last_div = '0;
    logic signed [9:0] last_d = '0;
    bit                exp_ovf = 1'b0;
    bit                acc_on = 1'b0;
    longint            sum_d = 0;
    longint            sum_p = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Compare DUT outputs against the scoreboard after every edge.
    task automatic score();
        exp_t e;
        bit   ev;
        ev = (sb.size() > 0) && (sb[0].due == cyc);
        check("d_valid", d_valid, ev);
        check("ovf_flag", ovf_flag, exp_ovf);
        if (ev) begin
            e = sb.pop_front();
            check("div_ratio", div_ratio, e.div);
            if (!e.dc) check("d_out", d_out, e.d);
            if (acc_on) sum_d += longint'(d_out);
            last_div = e.div;
            last_d   = e.dc ? d_out : e.d;
        end else begin
            check("hold_div", div_ratio, last_div);
            check("hold_d", d_out, last_d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        score();
    endtask

    task automatic apply(input bit e, input bit l, input logic [7:0] fi, input logic [23:0] ff,
                         input logic [11:0] g, input logic [8:0] xdiv, input logic signed [9:0] xd,
                         input bit dc);
        en        = e;
        fcw_load  = l;
        fcw_int   = fi;
        fcw_frac  = ff;
        kdtc_gain = g;
        if (e) sb.push_back('{due: cyc + 2, div: xdiv, d: xd, dc: dc});
        tick();
    endtask

    task automatic add(input bit e, input bit l, input logic [23:0] ff, input logic [11:0] g,
                       input logic [8:0] xdiv, input logic signed [9:0] xd);
        tbl.push_back('{en: e, load: l, fi: 8'd64, ff: ff, gain: g, xdiv: xdiv, xd: xd});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_div"}, div_ratio, 0);
        check({tag, "_d"}, d_out, 0);
        check({tag, "_valid"}, d_valid, 0);
        check({tag, "_ovf"}, ovf_flag, 0);
    endtask

    task automatic clear_model();
        sb.delete();
        last_div = '0;
        last_d   = '0;
        exp_ovf  = 1'b0;
    endtask

    logic signed [9:0] x5 [4] = '{-10'sd256, 10'sd0, 10'sd256, -10'sd512};

    initial begin
        // Half-integer FCW at unity gain
        add(0, 1, 24'h800000, 12'd2048, 9'd0, 10'sd0);
        for (int i = 0; i < 3; i++) begin
            add(1, 0, 24'h800000, 12'd2048, 9'd64, 10'sd0);
            add(1, 0, 24'h800000, 12'd2048, 9'd65, -10'sd512);
        end
        add(0, 0, 24'h800000, 12'd2048, 9'd0, 10'sd0);
        add(0, 0, 24'h800000, 12'd2048, 9'd0, 10'sd0);
        // Half gain
        for (int i = 0; i < 2; i++) begin
            add(1, 0, 24'h800000, 12'd1024, 9'd64, 10'sd0);
            add(1, 0, 24'h800000, 12'd1024, 9'd65, -10'sd256);
        end
        add(0, 0, 24'h800000, 12'd1024, 9'd0, 10'sd0);
        add(0, 0, 24'h800000, 12'd1024, 9'd0, 10'sd0);
        // en gaps: 1,0,1,1 then one more step to return acc to zero
        add(1, 0, 24'h800000, 12'd1024, 9'd64, 10'sd0);
        add(0, 0, 24'h800000, 12'd1024, 9'd0, 10'sd0);
        add(1, 0, 24'h800000, 12'd1024, 9'd65, -10'sd256);
        add(1, 0, 24'h800000, 12'd1024, 9'd64, 10'sd0);
        add(1, 0, 24'h800000, 12'd1024, 9'd65, -10'sd256);
        // Reload coincident with en: that step still adds 0x800000
        add(1, 1, 24'h400000, 12'd1024, 9'd64, 10'sd0);
        add(1, 0, 24'h400000, 12'd1024, 9'd64, 10'sd128);
        add(1, 0, 24'h400000, 12'd1024, 9'd65, -10'sd256);
        for (int i = 0; i < 3; i++) add(0, 0, 24'h400000, 12'd1024, 9'd0, 10'sd0);

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].en, tbl[i].load, tbl[i].fi, tbl[i].ff, tbl[i].gain, tbl[i].xdiv, tbl[i].xd, 1'b0);

        // Saturation at gain 4095: -1023.75 clamps to -512 and sets ovf_flag
        apply(0, 1, 8'd64, 24'h800000, 12'd4095, 9'd0, 10'sd0, 0);
        apply(1, 0, 8'd64, 24'h800000, 12'd4095, 9'd64, 10'sd0, 0);
        apply(1, 0, 8'd64, 24'h800000, 12'd4095, 9'd65, -10'sd512, 0);
        exp_ovf = 1'b1;
        for (int i = 0; i < 3; i++) apply(0, 0, 8'd64, 24'h800000, 12'd4095, 9'd0, 10'sd0, 0);
        exp_ovf = 1'b0;
        apply(0, 1, 8'd64, 24'h800000, 12'd4095, 9'd0, 10'sd0, 0);
        apply(0, 0, 8'd64, 24'h800000, 12'd4095, 9'd0, 10'sd0, 0);
        // Saturation and reload on the same edge: set wins
        apply(1, 0, 8'd64, 24'h800000, 12'd4095, 9'd64, 10'sd0, 0);
        apply(1, 1, 8'd64, 24'h800000, 12'd4095, 9'd65, -10'sd512, 0);
        exp_ovf = 1'b1;
        apply(0, 1, 8'd64, 24'h800000, 12'd4095, 9'd0, 10'sd0, 0);
        apply(0, 0, 8'd64, 24'h800000, 12'd4095, 9'd0, 10'sd0, 0);

        // Reset mid-stream with results in flight
        apply(1, 0, 8'd64, 24'h800000, 12'd2048, 9'd64, 10'sd0, 0);
        apply(1, 0, 8'd64, 24'h800000, 12'd2048, 9'd65, -10'sd512, 0);
        apply(1, 0, 8'd64, 24'h800000, 12'd2048, 9'd64, 10'sd0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        clear_model();
        apply(0, 0, 8'd64, 24'h800000, 12'd2048, 9'd0, 10'sd0, 0);
        apply(0, 0, 8'd64, 24'h800000, 12'd2048, 9'd0, 10'sd0, 0);
        rst_n = 1'b1;
        apply(0, 1, 8'd64, 24'h800000, 12'd2048, 9'd0, 10'sd0, 0);
        apply(1, 0, 8'd64, 24'h800000, 12'd2048, 9'd64, 10'sd0, 0);
        apply(1, 0, 8'd64, 24'h800000, 12'd2048, 9'd65, -10'sd512, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 8'd64, 24'h800000, 12'd2048, 9'd0, 10'sd0, 0);

        // Error feedback: quarter-step FCW at gain 2047, long-run mean check
        rst_n = 1'b0;
        #1;
        clear_model();
        apply(0, 0, 8'd64, 24'h400000, 12'd2047, 9'd0, 10'sd0, 0);
        rst_n = 1'b1;
        apply(0, 1, 8'd64, 24'h400000, 12'd2047, 9'd0, 10'sd0, 0);
        acc_on = 1'b1;
        begin
            longint macc;
            longint cen;
            longint t;
            longint diff;
            bit     c;
            macc = 0;
            for (int i = 0; i < 4096; i++) begin
                macc = macc + 64'h400000;
                c    = (macc >= (64'sd1 <<< 24));
                if (c) macc = macc - (64'sd1 <<< 24);
                cen   = macc - (64'sd1 <<< 23);
                t     = cen >>> 10;
                sum_p = sum_p + t * 2047;
                apply(1, 0, 8'd64, 24'h400000, 12'd2047, c ? 9'd65 : 9'd64,
                      (i < 4) ? x5[i] : 10'sd0, (i >= 4));
            end
            for (int i = 0; i < 3; i++) apply(0, 0, 8'd64, 24'h400000, 12'd2047, 9'd0, 10'sd0, 0);
            diff = sum_d * 32768 - sum_p;
            if (diff < 0) diff = -diff;
            check("ef_mean_within_0p01", (diff < 64'sd1342177) ? 1 : 0, 1);
            check("sb_drained", sb.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
